// File: rtl/cntdn_timer.sv
// Down-counting timer with load, clear, pause and terminal-count pulse.
// Optional macro CNTDN_AUTORELOAD_EN: reload from the last loaded value on expiry instead of stopping.
module cntdn_timer #(
   parameter int unsigned n = 10
) (
   input  logic         clk,
   input  logic         res_n,
   input  logic         enable,
   input  logic         clear,
   input  logic         load,
   input  logic [n-1:0] load_val,
   output logic [n-1:0] cnt_out,
   output logic         zero,
   output logic         tc,
   output logic         busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]   r_state;
   logic [n-1:0] r_cnt;
   logic [n-1:0] r_reload;
   logic         r_zero;
   logic         r_tc;
   logic         r_busy;

   logic [1:0]   w_state_nx;
   logic [n-1:0] w_cnt_nx;
   logic [n-1:0] w_reload_nx;
   logic         w_tc_nx;
   logic         w_dec;

   // Next-state and next-count: clear beats load beats decrement.
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_reload_nx = r_reload;
      w_tc_nx     = 1'b0;
      w_dec       = 1'b0;

      if (clear) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
      end else if (load) begin
         w_cnt_nx    = load_val;
         w_reload_nx = load_val;
         w_state_nx  = (load_val != '0) ? S_RUN : S_DONE;
      end else begin
         case (r_state)
            S_RUN: begin
               if (enable) w_dec = 1'b1;
               else        w_state_nx = S_PAUSE;
            end
            S_PAUSE: begin
               if (enable) begin
                  w_state_nx = S_RUN;
                  w_dec      = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Expiry on the 1->0 step; a zero count in RUN never wraps.
      if (w_dec) begin
         if (r_cnt == '0) begin
            w_state_nx = S_DONE;
         end else if (r_cnt == n'(1)) begin
            w_tc_nx = 1'b1;
`ifdef CNTDN_AUTORELOAD_EN
            w_cnt_nx   = r_reload;
            w_state_nx = S_RUN;
`else
            w_cnt_nx   = '0;
            w_state_nx = S_DONE;
`endif
         end else begin
            w_cnt_nx = r_cnt - n'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_reload <= '0;
         r_zero   <= 1'b1;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_reload <= w_reload_nx;
         r_zero   <= (w_cnt_nx == '0);
         r_tc     <= w_tc_nx;
         r_busy   <= (w_state_nx == S_RUN) || (w_state_nx == S_PAUSE);
      end
   end

   assign cnt_out = r_cnt;
   assign zero    = r_zero;
   assign tc      = r_tc;
   assign busy    = r_busy;

endmodule

// File: tb/tb_cntdn_timer.sv
// Directed plus randomized bench for cntdn_timer against a behavioural count model.
module tb_cntdn_timer;

   localparam int unsigned N   = 10;
   localparam int          MAX = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         res_n = 1'b0;
   logic         enable = 1'b0;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [N-1:0] load_val = '0;
   logic [N-1:0] cnt_out;
   logic         zero;
   logic         tc;
   logic         busy;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: a count, the last loaded value, and whether a countdown session is live.
   int m_cnt    = 0;
   int m_reload = 0;
   bit m_active = 1'b0;
   bit m_tc     = 1'b0;

   always #5 clk = ~clk;

   cntdn_timer #(.n(N)) dut (
      .clk      (clk),
      .res_n    (res_n),
      .enable   (enable),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .cnt_out  (cnt_out),
      .zero     (zero),
      .tc       (tc),
      .busy     (busy)
   );

   function automatic void model_reset();
      m_cnt    = 0;
      m_reload = 0;
      m_active = 1'b0;
      m_tc     = 1'b0;
   endfunction

   function automatic void model_edge();
      m_tc = 1'b0;
      if (!res_n) begin
         model_reset();
      end else if (clear) begin
         m_cnt    = 0;
         m_active = 1'b0;
      end else if (load) begin
         m_cnt    = int'(load_val);
         m_reload = int'(load_val);
         m_active = (load_val != '0);
      end else if (m_active && enable && m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_tc = 1'b1;
`ifdef CNTDN_AUTORELOAD_EN
            m_cnt = m_reload;
`else
            m_active = 1'b0;
`endif
         end
      end
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      cmp({tag, ".cnt"},  32'(cnt_out), 32'(m_cnt));
      cmp({tag, ".zero"}, 32'(zero),    32'(m_cnt == 0));
      cmp({tag, ".tc"},   32'(tc),      32'(m_tc));
      cmp({tag, ".busy"}, 32'(busy),    32'(m_active));
   endtask

   task automatic drive(input bit c, input bit l, input bit e, input logic [N-1:0] v);
      clear    = c;
      load     = l;
      enable   = e;
      load_val = v;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset held for 100 time units
      #50;
      check_all("reset_hold");
      cmp("reset_zero", 32'(zero), 32'd1);
      #50;
      res_n = 1'b1;

      // Load 5 and count to expiry
      drive(0, 1, 1, N'(5));
      step("r031_load");
      cmp("r031_cnt5", 32'(cnt_out), 32'd5);
      drive(0, 0, 1, '0);
      for (int i = 0; i < 5; i++) step("r031_run");
`ifndef CNTDN_AUTORELOAD_EN
      cmp("r031_end_cnt", 32'(cnt_out), 32'd0);
      cmp("r031_end_tc",  32'(tc),      32'd1);
      cmp("r031_end_busy", 32'(busy),   32'd0);
      step("r031_after");
      cmp("r031_tc_drop", 32'(tc), 32'd0);
      for (int i = 0; i < 3; i++) step("r031_done_hold");
`endif

      // Pause at 6 for 10 cycles, then resume
      drive(0, 1, 1, N'(8));
      step("r032_load");
      drive(0, 0, 1, '0);
      step("r032_run");
      step("r032_run");
      cmp("r032_at6", 32'(cnt_out), 32'd6);
      drive(0, 0, 0, '0);
      for (int i = 0; i < 10; i++) step("r032_pause");
      cmp("r032_pause_busy", 32'(busy), 32'd1);
      cmp("r032_pause_cnt",  32'(cnt_out), 32'd6);
      drive(0, 0, 1, '0);
      step("r032_resume");
      cmp("r032_resume5", 32'(cnt_out), 32'd5);
      step("r032_resume");

      // Clear and load together at count 3
      drive(0, 1, 1, N'(5));
      step("r033_load");
      drive(0, 0, 1, '0);
      step("r033_run");
      step("r033_run");
      drive(1, 1, 1, N'(9));
      step("r033_clr");
      cmp("r033_cnt", 32'(cnt_out), 32'd0);
      cmp("r033_busy", 32'(busy), 32'd0);
      drive(0, 0, 1, '0);
      for (int i = 0; i < 4; i++) step("r033_idle");

      // Load collides with the 1->0 step
      drive(0, 1, 1, N'(2));
      step("r034_load");
      drive(0, 0, 1, '0);
      step("r034_run");
      drive(0, 1, 1, N'(7));
      step("r034_collide");
      cmp("r034_cnt", 32'(cnt_out), 32'd7);
      cmp("r034_tc",  32'(tc),      32'd0);

      // Asynchronous reset mid-count
      drive(0, 1, 1, N'(6));
      step("r035_load");
      drive(0, 0, 1, '0);
      step("r035_run");
      step("r035_run");
      #3;
      res_n = 1'b0;
      model_reset();
      #1;
      check_all("r035_async");
      step("r035_held");
      #4;
      res_n = 1'b1;
      for (int i = 0; i < 4; i++) step("r035_after");
      cmp("r035_stays0", 32'(cnt_out), 32'd0);

`ifdef CNTDN_AUTORELOAD_EN
      // Auto-reload period of 3
      begin
         int pulses = 0;
         drive(0, 1, 0, N'(3));
         step("r036_load");
         drive(0, 0, 1, '0);
         for (int i = 0; i < 12; i++) begin
            step("r036_run");
            if (tc) pulses++;
         end
         cmp("r036_pulses", 32'(pulses), 32'd4);
      end
`endif

      // Randomized mix of clear/load/enable
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] v;
         int sel = $urandom_range(0, 9);
         v = (sel == 0) ? N'(MAX) : (sel == 1) ? '0 : N'($urandom_range(1, 12));
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), v);
         step("rand");
      end

      // Full-range count from 2^n-1
      drive(0, 1, 0, N'(MAX));
      step("max_load");
      cmp("max_cnt", 32'(cnt_out), 32'(MAX));
      drive(0, 0, 1, '0);
      for (int i = 0; i < MAX; i++) step("max_run");
`ifndef CNTDN_AUTORELOAD_EN
      cmp("max_end_tc", 32'(tc), 32'd1);
`endif
      drive(0, 0, 0, '0);
      step("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cntdn_timer.md
CNTDN_TIMER -- requirements
Module: cntdn_timer

Interface
REQ-001 Parameter: n, default 10, counter width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 res_n  input  1  reset; asynchronous assertion and active-low.
REQ-004 enable  input  1  count permission; decrement allowed while high.
REQ-005 clear  input  1  synchronous clear of count and state.
REQ-006 load  input  1  synchronous load strobe for load_val.
REQ-007 load_val  input  n  start value captured on load.
REQ-008 cnt_out  output  n  current count, registered.
REQ-009 zero  output  1  high while cnt_out == 0, registered.
REQ-010 tc  output  1  terminal-count pulse, one clk wide, registered.
REQ-011 busy  output  1  high in RUN or PAUSE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-013 Per-edge priority SHALL be: clear > load > enable/decrement.
REQ-014 clear=1 SHALL give cnt_out=0, tc=0 and state IDLE on the next edge; the reload register is kept.
REQ-015 load=1 (no clear) SHALL give cnt_out=load_val and reload register=load_val, with tc=0; next state is RUN when load_val!=0, else DONE.
REQ-016 In RUN with enable=1, cnt_out SHALL decrement by 1 per edge.
REQ-017 In RUN with enable=0, cnt_out SHALL hold and state SHALL go to PAUSE.
REQ-018 In PAUSE with enable=1, state SHALL return to RUN and cnt_out SHALL decrement on that same edge.
REQ-019 A RUN decrement from 1 to 0 SHALL assert tc for exactly the following cycle and enter DONE (macro-off behaviour).
REQ-020 In IDLE and DONE, enable SHALL be ignored; cnt_out SHALL never wrap below 0.
REQ-021 zero SHALL equal (cnt_out == 0) for the same cycle, with no combinational path from inputs.
REQ-022 tc SHALL be 0 in every cycle other than the one stated in REQ-019/REQ-029.
REQ-023 A load arriving in the same cycle as a 1->0 decrement SHALL win: no tc, count = load_val.
REQ-024 A load during RUN or PAUSE SHALL restart the count from load_val.
REQ-025 Arithmetic SHALL be n-bit unsigned; load_val = 2^n-1 SHALL be accepted and counted fully.

Reset
REQ-026 res_n=0 SHALL immediately force cnt_out=0, zero=1, tc=0, busy=0, state IDLE and reload register=0.
REQ-027 Deassertion of res_n mid-count SHALL leave the block in IDLE; no count resumes without a new load.
REQ-028 Reset SHALL override clear, load and enable.

Configuration
REQ-029 Macro CNTDN_AUTORELOAD_EN defined: a RUN 1->0 decrement SHALL pulse tc and load cnt_out from the reload register on the same edge, staying in RUN (period = reload value cycles); zero stays 0 in that case.
REQ-030 Macro CNTDN_AUTORELOAD_EN undefined: REQ-019 behaviour applies; the block does not reload.

Verification (n=10)
REQ-031 Reset low 100 time units, then load_val=5 with load=1 for one cycle and enable=1 -> cnt_out 5,4,3,2,1,0; tc high exactly one cycle after 0 is reached; zero=1; state DONE; busy=0.
REQ-032 load_val=8 and count to 6, then enable=0 for 10 cycles, then enable=1 -> cnt_out holds 6 with busy=1 while paused, then 5,4,... with no lost or extra step.
REQ-033 cnt_out=3 in RUN, then clear=1 and load=1 in the same cycle -> cnt_out=0, state IDLE, tc=0; later enable=1 -> cnt_out stays 0.
REQ-034 cnt_out=1 with enable=1, then load=1 with load_val=7 in the same cycle -> cnt_out=7 and tc never asserts.
REQ-035 res_n=0 pulsed asynchronously at cnt_out=4 -> outputs reset without waiting for a clk edge; after release, enable=1 -> cnt_out stays 0.
REQ-036 With CNTDN_AUTORELOAD_EN defined, load_val=3 and enable=1 for 12 cycles -> tc pulses every 3 cycles (4 pulses), cnt_out sequence 3,2,1,3,2,1,...
